ahb_mem_slave: RTL and testbench

AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

---
 rtl/rot_ahb_pkg.sv | 33 +++
 rtl/mem_slave_ram.sv | 27 ++
 rtl/ahb_mem_slave.sv | 144 ++++++++++++++
 tb/tb_ahb_mem_slave.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_ahb_pkg.sv
// AHB-Lite encodings and lane helpers shared by the memory slave and the DMA.
package rot_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1
  } hresp_e;

  // Little-endian byte lanes touched by a legal transfer of the given size/offset.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << off;
      HSIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_slave_ram.sv
// Word-wide storage: synchronous byte-enabled write, asynchronous read.
module mem_slave_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: WAIT_STATES stall cycles per legal transfer, two-cycle ERROR for illegal ones.
// Zero-wait mode pipelines one transfer per cycle, forwarding write data into a same-word read.
module ahb_mem_slave
  import rot_ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1
) (
  input  logic        I_MEM_HCLK,
  input  logic        I_MEM_HRESET_N,
  input  logic        I_MEM_HSEL,
  input  logic [31:0] I_MEM_HADDR,
  input  logic [1:0]  I_MEM_HTRANS,
  input  logic        I_MEM_HWRITE,
  input  logic [2:0]  I_MEM_HSIZE,
  input  logic [3:0]  I_MEM_HBURST,
  input  logic [31:0] I_MEM_HWDATA,
  output logic [31:0] O_MEM_HRDATA,
  output logic        O_MEM_HREADY,
  output logic [1:0]  O_MEM_HRESP
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

  state_e        state, state_nxt;
  logic [2:0]    wait_cnt, wait_cnt_nxt;
  logic [AW-1:0] cap_idx;
  logic [1:0]    cap_off;
  logic [2:0]    cap_size;
  logic          cap_write;
  logic [31:0]   hrdata;

  logic [31:0]   offset;
  logic [AW-1:0] live_idx;
  logic          in_range, misaligned, legal, capture;
  logic          go_data_now, wait_done, rd_load;
  logic          wr_en, fwd;
  logic [3:0]    wr_be;
  logic [AW-1:0] rd_idx;
  logic [31:0]   ram_rdata, rd_word;

  // Unsigned subtraction makes addresses below the base wrap far out of range.
  assign offset     = I_MEM_HADDR - BASE_ADDR;
  assign live_idx   = offset[AW+1:2];
  assign in_range   = (offset[31:AW+2] == '0);
  assign misaligned = ((I_MEM_HSIZE == HSIZE_HALF) && I_MEM_HADDR[0]) ||
                      ((I_MEM_HSIZE == HSIZE_WORD) && (I_MEM_HADDR[1:0] != 2'b00));
  assign legal      = in_range && (I_MEM_HSIZE <= HSIZE_WORD) && !misaligned;

  assign O_MEM_HREADY = (state != S_WAIT) && (state != S_ERR1);
  assign capture      = I_MEM_HSEL && O_MEM_HREADY &&
                        ((I_MEM_HTRANS == HTRANS_NONSEQ) || (I_MEM_HTRANS == HTRANS_SEQ));

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    O_MEM_HRESP  = HRESP_OKAY;
    case (state)
      S_WAIT: begin
        if (wait_cnt == 3'd0) state_nxt = S_DATA;
        else                  wait_cnt_nxt = wait_cnt - 3'd1;
      end
      S_ERR1: begin
        O_MEM_HRESP = HRESP_ERROR;
        state_nxt   = S_ERR2;
      end
      default: begin
        if (state == S_ERR2) O_MEM_HRESP = HRESP_ERROR;
        if (!capture) begin
          state_nxt = S_IDLE;
        end else if (!legal) begin
          state_nxt = S_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_nxt    = S_WAIT;
          wait_cnt_nxt = WS_LOAD;
        end else begin
          state_nxt = S_DATA;
        end
      end
    endcase
  end

  assign go_data_now = capture && legal && (WAIT_STATES == 0);
  assign wait_done   = (state == S_WAIT) && (wait_cnt == 3'd0);
  assign rd_load     = (go_data_now && !I_MEM_HWRITE) || (wait_done && !cap_write);

  assign wr_en  = (state == S_DATA) && cap_write;
  assign wr_be  = byte_en(cap_size, cap_off);
  assign rd_idx = go_data_now ? live_idx : cap_idx;
  // A zero-wait read captured under a write DATA cycle sees memory before that write lands.
  assign fwd    = wr_en && (cap_idx == rd_idx);

  always_comb begin
    rd_word = ram_rdata;
    for (int b = 0; b < 4; b++) begin
      if (fwd && wr_be[b]) rd_word[8*b +: 8] = I_MEM_HWDATA[8*b +: 8];
    end
  end

  always_ff @(posedge I_MEM_HCLK or negedge I_MEM_HRESET_N) begin
    if (!I_MEM_HRESET_N) begin
      state     <= S_IDLE;
      wait_cnt  <= 3'd0;
      cap_idx   <= '0;
      cap_off   <= 2'b00;
      cap_size  <= 3'd0;
      cap_write <= 1'b0;
      hrdata    <= 32'h0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (capture) begin
        cap_idx   <= live_idx;
        cap_off   <= I_MEM_HADDR[1:0];
        cap_size  <= I_MEM_HSIZE;
        cap_write <= I_MEM_HWRITE;
      end
      if (rd_load) hrdata <= rd_word;
    end
  end

  assign O_MEM_HRDATA = hrdata;

  mem_slave_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (I_MEM_HCLK),
    .we    (wr_en),
    .be    (wr_be),
    .waddr (cap_idx),
    .wdata (I_MEM_HWDATA),
    .raddr (rd_idx),
    .rdata (ram_rdata)
  );

  logic unused_ok;
  assign unused_ok = ^{I_MEM_HBURST, offset[1:0]};

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Two slaves (0 and 2 wait states) on shared stimulus, checked against a byte-lane memory model.
module tb_ahb_mem_slave;

  localparam int DEPTH = 64;
  localparam logic [31:0] BASE = 32'h0;

  typedef struct {
    bit          wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        hsel_r;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hburst;
  logic [31:0] hwdata;
  logic        hsel_a, hsel_b;
  logic [31:0] rdata_a, rdata_b;
  logic        rdy_a, rdy_b;
  logic [1:0]  resp_a, resp_b;
  logic        cur_hready;
  logic [1:0]  cur_hresp;
  logic [31:0] cur_hrdata;

  int          n_chk = 0;
  int          n_pass = 0;
  int          ws_of [2] = '{0, 2};
  logic [31:0] mem_m [2][DEPTH];
  logic [31:0] last_rd [2];
  op_t         pq [$];

  always #5 clk = ~clk;

  assign hsel_a     = hsel_r & ~sel;
  assign hsel_b     = hsel_r & sel;
  assign cur_hready = sel ? rdy_b : rdy_a;
  assign cur_hresp  = sel ? resp_b : resp_a;
  assign cur_hrdata = sel ? rdata_b : rdata_a;

  ahb_mem_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_a (
    .I_MEM_HCLK(clk), .I_MEM_HRESET_N(rst_n), .I_MEM_HSEL(hsel_a), .I_MEM_HADDR(haddr),
    .I_MEM_HTRANS(htrans), .I_MEM_HWRITE(hwrite), .I_MEM_HSIZE(hsize), .I_MEM_HBURST(hburst),
    .I_MEM_HWDATA(hwdata), .O_MEM_HRDATA(rdata_a), .O_MEM_HREADY(rdy_a), .O_MEM_HRESP(resp_a)
  );

  ahb_mem_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut_b (
    .I_MEM_HCLK(clk), .I_MEM_HRESET_N(rst_n), .I_MEM_HSEL(hsel_b), .I_MEM_HADDR(haddr),
    .I_MEM_HTRANS(htrans), .I_MEM_HWRITE(hwrite), .I_MEM_HSIZE(hsize), .I_MEM_HBURST(hburst),
    .I_MEM_HWDATA(hwdata), .O_MEM_HRDATA(rdata_b), .O_MEM_HREADY(rdy_b), .O_MEM_HRESP(resp_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic bit is_legal(input logic [2:0] sz, input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (sz > 3'd2) return 1'b0;
    if (sz == 3'd1 && a[0] != 1'b0) return 1'b0;
    if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b0;
    return (off >> 2) < DEPTH;
  endfunction

  function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
    int idx;
    idx = int'((a - BASE) >> 2);
    return mem_m[d][idx];
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] wd);
    int idx, lane;
    idx = int'((a - BASE) >> 2);
    for (int k = 0; k < (1 << sz); k++) begin
      lane = int'(a[1:0]) + k;
      mem_m[d][idx][8*lane +: 8] = wd[8*lane +: 8];
    end
  endtask

  // One non-pipelined transfer: address phase, then data phase until HREADY.
  task automatic xfer(input int d, input bit wr, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, output int lows, output logic [1:0] rf,
                      output logic [1:0] rr, output logic [31:0] rd);
    @(negedge clk);
    sel = (d == 1); hsel_r = 1'b1; htrans = 2'd2; haddr = a; hwrite = wr; hsize = sz;
    hburst = 4'($urandom_range(0, 7));
    @(negedge clk);
    hsel_r = 1'b0; htrans = 2'd0; hwdata = wd;
    lows = 0; rf = 2'd0;
    while (!cur_hready && lows < 16) begin
      if (lows == 0) rf = cur_hresp;
      lows++;
      @(negedge clk);
    end
    rr = cur_hresp;
    rd = cur_hrdata;
  endtask

  task automatic check_xfer(input int d, input bit wr, input logic [2:0] sz,
                            input logic [31:0] a, input logic [31:0] wd);
    int lows;
    logic [1:0] rf, rr;
    logic [31:0] rd, e;
    bit legal;
    legal = is_legal(sz, a);
    e = last_rd[d];
    if (legal && !wr) e = model_word(d, a);
    xfer(d, wr, sz, a, wd, lows, rf, rr, rd);
    if (legal) begin
      chk("wait_cycles", lows, ws_of[d]);
      chk("resp_okay", 32'(rr), 32'd0);
    end else begin
      chk("err_cycles", lows, 1);
      chk("err_first", 32'(rf), 32'd1);
      chk("err_second", 32'(rr), 32'd1);
    end
    chk(wr ? "rdata_hold" : "rdata", rd, e);
    last_rd[d] = e;
    if (legal && wr) model_write(d, a, sz, wd);
  endtask

  task automatic add_op(input bit wr, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd);
    op_t o;
    o.wr = wr; o.sz = sz; o.a = a; o.wd = wd;
    pq.push_back(o);
  endtask

  // Back-to-back pipelined transfers on the zero-wait slave; HREADY must never drop.
  task automatic run_pipe();
    int n;
    op_t o;
    logic [31:0] e;
    n = pq.size();
    sel = 1'b0;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        o = pq[i-1];
        chk("pipe_ready", 32'(cur_hready), 32'd1);
        chk("pipe_resp", 32'(cur_hresp), 32'd0);
        if (o.wr) begin
          model_write(0, o.a, o.sz, o.wd);
        end else begin
          e = model_word(0, o.a);
          chk("pipe_rdata", cur_hrdata, e);
          last_rd[0] = e;
        end
        hwdata = o.wd;
      end
      if (i < n) begin
        hsel_r = 1'b1; htrans = (i == 0) ? 2'd2 : 2'd3;
        haddr = pq[i].a; hwrite = pq[i].wr; hsize = pq[i].sz;
      end else begin
        hsel_r = 1'b0; htrans = 2'd0;
      end
    end
    pq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, wd, old;
    logic [2:0]  sz;
    int          idx, off, r, d;

    rst_n = 1'b0; sel = 1'b0; hsel_r = 1'b0; haddr = '0; htrans = 2'd0;
    hwrite = 1'b0; hsize = 3'd0; hburst = 4'd0; hwdata = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sel = (k == 1);
      #1;
      chk("reset_hready", 32'(cur_hready), 32'd1);
      chk("reset_hresp", 32'(cur_hresp), 32'd0);
      chk("reset_hrdata", cur_hrdata, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 2; k++)
      for (int w = 0; w < DEPTH; w++) check_xfer(k, 1'b1, 3'd2, 32'(w * 4), $urandom);

    // Word write then read on the zero-wait slave.
    check_xfer(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    check_xfer(0, 1'b0, 3'd2, 32'h10, 32'h0);
    // Byte and half-word lane merges.
    check_xfer(0, 1'b1, 3'd2, 32'h10, 32'h11223344);
    check_xfer(0, 1'b1, 3'd0, 32'h13, 32'hAA000000);
    check_xfer(0, 1'b0, 3'd2, 32'h10, 32'h0);
    check_xfer(0, 1'b1, 3'd1, 32'h12, 32'h55660000);
    check_xfer(0, 1'b0, 3'd2, 32'h10, 32'h0);
    chk("half_merge_value", last_rd[0], 32'h55663344);
    // Two wait states on a read of word 0.
    check_xfer(1, 1'b0, 3'd2, 32'h0, 32'h0);
    // Illegal transfers on both slaves, then memory read back.
    for (int k = 0; k < 2; k++) begin
      check_xfer(k, 1'b1, 3'd2, 32'h02, 32'hFFFFFFFF);
      check_xfer(k, 1'b1, 3'd3, 32'h00, 32'hFFFFFFFF);
      check_xfer(k, 1'b1, 3'd2, 32'(DEPTH * 4), 32'hFFFFFFFF);
      check_xfer(k, 1'b1, 3'd1, 32'h05, 32'hFFFFFFFF);
      check_xfer(k, 1'b0, 3'd2, 32'h00, 32'h0);
    end

    // BUSY and unselected transfers: zero-wait OKAY, no memory access.
    @(negedge clk);
    sel = 1'b1; hsel_r = 1'b1; htrans = 2'd1; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
    hwdata = 32'h0BAD0BAD;
    @(negedge clk);
    chk("busy_ready", 32'(cur_hready), 32'd1);
    chk("busy_resp", 32'(cur_hresp), 32'd0);
    hsel_r = 1'b0; htrans = 2'd2;
    @(negedge clk);
    chk("unsel_ready", 32'(cur_hready), 32'd1);
    htrans = 2'd0;
    check_xfer(1, 1'b0, 3'd2, 32'h10, 32'h0);

    // Pipelined write/read forwarding and sustained SEQ throughput.
    add_op(1'b1, 3'd2, 32'h20, 32'h12345678);
    add_op(1'b0, 3'd2, 32'h20, 32'h0);
    add_op(1'b1, 3'd0, 32'h25, 32'h0000AB00);
    add_op(1'b0, 3'd2, 32'h24, 32'h0);
    for (int i = 0; i < 4; i++) add_op(1'b1, 3'd2, 32'(32'h40 + 4 * i), $urandom);
    for (int i = 3; i >= 0; i--) add_op(1'b0, 3'd2, 32'(32'h40 + 4 * i), 32'h0);
    add_op(1'b1, 3'd1, 32'h32, 32'hBEEF0000);
    add_op(1'b0, 3'd1, 32'h30, 32'h0);
    run_pipe();
    check_xfer(0, 1'b0, 3'd2, 32'h20, 32'h0);

    // Randomized traffic, mostly legal.
    for (int n = 0; n < 250; n++) begin
      d   = int'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      idx = int'($urandom_range(0, DEPTH - 1));
      off = (sz == 3'd0) ? int'($urandom_range(0, 3)) : (sz == 3'd1) ? 2 * int'($urandom_range(0, 1)) : 0;
      a   = 32'(idx * 4 + off);
      r   = int'($urandom_range(0, 19));
      if (r == 0) a = a ^ 32'h1;
      else if (r == 1) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000) * 4);
      else if (r == 2) a = 32'hFFFF_FFFC;
      wd = $urandom;
      check_xfer(d, $urandom_range(0, 1) == 1, sz, a, wd);
    end

    // Reset while a write sits in its wait states: abandoned, word keeps its value.
    old = mem_m[1][12];
    @(negedge clk);
    sel = 1'b1; hsel_r = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2;
    @(negedge clk);
    hsel_r = 1'b0; htrans = 2'd0; hwdata = ~old;
    chk("wait_hready_low", 32'(cur_hready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_hready", 32'(cur_hready), 32'd1);
    chk("rst_wait_hresp", 32'(cur_hresp), 32'd0);
    chk("rst_wait_hrdata", cur_hrdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = '0; last_rd[1] = '0;
    check_xfer(1, 1'b0, 3'd2, 32'h30, 32'h0);
    chk("rst_word_kept", last_rd[1], old);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
